pac_sprite_renderer: RTL
========================

Name: pac_sprite_renderer

Overview:
Consumer stage for the 96x16 Pac-Man sprite ROM. Converts the VGA scan position and the player's position and direction into a ROM row address, and animates the mouth between the open-direction sprite and the closed sprite. Returns a registered per-pixel pac_on flag to the colour mapper. Sits between the VGA controller/ball-motion logic and color_mapper.

Parameters:
ANIM_FRAMES, 4, number of frame ticks between mouth toggles while moving (legal range 1..15)
PAC_SIZE, 16, sprite width and height in pixels; fixed by the ROM format and not overridable

Ports:
Clk  in  1  system clock (50 MHz pixel-domain clock)
Reset_n  in  1  reset, asynchronous, active-low
frame_clk  in  1  vsync-rate frame strobe, asynchronous to Clk semantics; synchronised internally
DrawX  in  10  current scan column (0..639 visible)
DrawY  in  10  current scan row (0..479 visible)
PacX  in  10  sprite top-left column
PacY  in  10  sprite top-left row
dir  in  2  requested facing: 00 left, 01 right, 10 up, 11 down
moving  in  1  1 = player moving (animate), 0 = stationary
rom_data  in  16  ROM row for rom_addr, combinational return, MSB = leftmost pixel
rom_addr  out  7  ROM row address
pac_on  out  1  pixel at the DrawX/DrawY issued two cycles earlier belongs to Pac-Man
mouth_open  out  1  current animation phase (debug/status)
dir_q  out  2  direction latched for the current frame

Behaviour:
- Reset (async assert, sync release on Clk): rom_addr=0, pac_on=0, mouth_open=1, dir_q=00, anim counter=0, synchroniser flops=0, pipeline valid bits=0.
- frame_clk path: 2-flop synchroniser, then rising-edge detect. The result is frame_tick, a 1-cycle pulse per frame.
- On frame_tick:
  - dir_q <= dir.
  - If moving=0: counter <= 0 and mouth_open <= 1.
  - Else if counter == ANIM_FRAMES-1: counter <= 0 and mouth_open toggles.
  - Else: counter increments.
- dir and moving are sampled only on frame_tick, so there is no mid-frame sprite change.
- Sprite base selection:
  - mouth_open=0 gives 16 (closed), regardless of dir_q.
  - Otherwise by dir_q: left 0, right 80, up 48, down 64.
  - Base 32 (ghost) is never issued.
- Stage 1, registered on every Clk edge:
  - dx = {1'b0,DrawX} - {1'b0,PacX} and dy = {1'b0,DrawY} - {1'b0,PacY}, both computed in 11 bits.
  - in_box = (DrawX >= PacX) && (DrawX < PacX+16) && (DrawY >= PacY) && (DrawY < PacY+16). Compare in 11 bits so that PacX/PacY near 1023 do not wrap.
  - rom_addr <= base + dy[3:0] when in_box, else rom_addr holds 0.
  - col_q <= dx[3:0]; in_box_q <= in_box.
- Stage 2, registered: pac_on <= in_box_q & rom_data[15 - col_q].
- Latency:
  - rom_addr is valid 1 cycle after DrawX/DrawY.
  - pac_on is valid 2 cycles after DrawX/DrawY.
  - Throughput is 1 pixel/clock with no stalls.
- Frame/pixel interaction: if frame_tick and a pixel arrive in the same cycle, stage 1 uses the pre-update base. The new dir_q/mouth_open take effect from the next cycle.
- Reset mid-frame: pipeline flushes, pac_on=0 immediately (async), and animation restarts open.
- ANIM_FRAMES=1: mouth toggles on every frame tick while moving.

Test Plan:
1. Reset_n=0 with random inputs: rom_addr=0, pac_on=0, mouth_open=1, dir_q=00 immediately. They hold for 3 cycles after release with no frame_tick.
2. PacX=100, PacY=50, dir=00, moving=0, one frame_tick; sweep DrawX=100..115 at DrawY=53; bench ROM returns 16'h8001.
   - rom_addr=3 one cycle after each pixel.
   - pac_on=1 only for DrawX=100 and 115, two cycles later.
   - DrawX=99 and 116 give pac_on=0.
3. moving=1, ANIM_FRAMES=4, dir=01: issue 8 frame_ticks.
   - mouth_open=1,1,1,0,0,0,0,1 after ticks 1..8.
   - Base for DrawY=PacY is 80 while open and 16 while closed.
4. dir changes 10→11 mid-frame without a frame_tick: rom_addr base stays 48. After the next frame_tick, the base is 64 and dir_q=11.
5. PacX=1020, PacY=470, DrawX=1, DrawY=470: in_box=0, pac_on=0 (no wrap). DrawX=1023 gives in_box=1 and col=3.
6. Assert Reset_n low for 1 cycle mid-sweep while pac_on=1: pac_on drops asynchronously, the counter clears, and the next pixels resume with 2-cycle latency.

Source files
------------

// File: rtl/pac_sprite_renderer_if.sv
// Pixel/ROM bundle between the VGA/motion side (master) and the sprite renderer (slave).
// Pure wiring; no latency and no backpressure.
interface pac_sprite_renderer_if;
  logic        frame_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  PacX;
  logic [9:0]  PacY;
  logic [1:0]  dir;
  logic        moving;
  logic [15:0] rom_data;
  logic [6:0]  rom_addr;
  logic        pac_on;
  logic        mouth_open;
  logic [1:0]  dir_q;

  modport master (
    output frame_clk, DrawX, DrawY, PacX, PacY, dir, moving, rom_data,
    input  rom_addr, pac_on, mouth_open, dir_q
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, PacX, PacY, dir, moving, rom_data,
    output rom_addr, pac_on, mouth_open, dir_q
  );
endinterface

// File: rtl/pac_sprite_renderer.sv
// Pac-Man sprite renderer: scan position -> ROM row address, mouth animation, per-pixel pac_on.
// Latency: rom_addr 1 cycle, pac_on 2 cycles after DrawX/DrawY; 1 pixel/clock, never stalls.
module pac_sprite_renderer #(
  parameter int ANIM_FRAMES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  pac_sprite_renderer_if.slave  bus
);
  localparam int         PAC_SIZE = 16;
  localparam logic [3:0] CNT_LAST = 4'(ANIM_FRAMES - 1);

  logic        sync1_q, sync2_q, sync3_q;
  logic        frame_tick;
  logic [3:0]  cnt_q, cnt_d;
  logic        mouth_q, mouth_d;
  logic [1:0]  dir_r_q, dir_r_d;
  logic [6:0]  base;
  logic [10:0] pac_x_end, pac_y_end;
  logic [3:0]  dx_lo, dy_lo;
  logic        in_box;
  logic [6:0]  rom_addr_q, rom_addr_d;
  logic [3:0]  col_q;
  logic        in_box_q;
  logic        pac_on_q, pac_on_d;

  // sync3_q is the previous synchronised level, used for rising-edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign frame_tick = sync2_q & ~sync3_q;

  always_comb begin
    cnt_d   = cnt_q;
    mouth_d = mouth_q;
    dir_r_d = dir_r_q;
    if (frame_tick) begin
      dir_r_d = bus.dir;
      if (!bus.moving) begin
        cnt_d   = 4'd0;
        mouth_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = 4'd0;
        mouth_d = ~mouth_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= 4'd0;
      mouth_q <= 1'b1;
      dir_r_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      mouth_q <= mouth_d;
      dir_r_q <= dir_r_d;
    end
  end

  // Closed sprite overrides direction; the ghost row block at 32 is never selected
  always_comb begin
    base = 7'd16;
    if (mouth_q) begin
      case (dir_r_q)
        2'b00:   base = 7'd0;
        2'b01:   base = 7'd80;
        2'b10:   base = 7'd48;
        default: base = 7'd64;
      endcase
    end
  end

  // 11-bit bounds so a sprite parked near column/row 1023 does not wrap
  assign pac_x_end = {1'b0, bus.PacX} + 11'(PAC_SIZE);
  assign pac_y_end = {1'b0, bus.PacY} + 11'(PAC_SIZE);
  assign in_box = ({1'b0, bus.DrawX} >= {1'b0, bus.PacX}) && ({1'b0, bus.DrawX} < pac_x_end) &&
                  ({1'b0, bus.DrawY} >= {1'b0, bus.PacY}) && ({1'b0, bus.DrawY} < pac_y_end);
  assign dx_lo = bus.DrawX[3:0] - bus.PacX[3:0];
  assign dy_lo = bus.DrawY[3:0] - bus.PacY[3:0];

  assign rom_addr_d = in_box ? (base + {3'b000, dy_lo}) : 7'd0;
  assign pac_on_d   = in_box_q & bus.rom_data[4'd15 - col_q];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= 7'd0;
      col_q      <= 4'd0;
      in_box_q   <= 1'b0;
      pac_on_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_q      <= dx_lo;
      in_box_q   <= in_box;
      pac_on_q   <= pac_on_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pac_on     = pac_on_q;
  assign bus.mouth_open = mouth_q;
  assign bus.dir_q      = dir_r_q;
endmodule
